neo_sample_window: RTL and testbench
====================================

# neo_sample_window

Parametrised successor to the front-end sample memory. Stores a stream of signed samples in a circular buffer of depth M with a valid/ready handshake. Presents the three-sample window x[n], x[n-1], x[n-2] required by the NEO datapath. Also provides a registered lag-addressed read port for history inspection. Sits between the ADC sample interface and the NEO arithmetic stage.

## Interface
- N, 8, sample width in bits (signed)
- M, 16, buffer depth; power of two, M >= 4
- Clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous flush of pointers, count and window; memory contents untouched
- in_valid  in  1  sample offered
- in_data  in  N  signed sample
- in_ready  out  1  block accepts sample this cycle
- out_valid  out  1  window valid
- out_ready  in  1  downstream consumes window
- x0  out  N  newest sample x[n]
- x1  out  N  x[n-1]
- x2  out  N  oldest sample x[n-2]
- lag  in  $clog2(M)  history offset; 0 = newest stored sample
- lag_data  out  N  registered history read
- count  out  $clog2(M)+1  stored samples, saturating at M

## Operation
- Accept = in_valid && in_ready.
- in_ready = !clear && (!out_valid || out_ready).
- On accept:
  - mem[wptr] <= in_data; wptr <= wptr+1 mod M (wraps M-1 -> 0).
  - count <= min(count+1, M).
  - Window shifts: x2 <= x1, x1 <= x0, x0 <= in_data.
- State machine (neo_pkg::win_state_t):
  - PRIME: fewer than 3 samples since reset/clear. out_valid = 0.
  - STREAM: out_valid = 1 while a window is held.
  - Transitions:
    - PRIME -> STREAM on the accept that makes the third sample; out_valid rises.
    - STREAM stays STREAM.
    - out_valid <= accept ? 1 : (out_valid && !out_ready).
- Held window: x0..x2 do not change while out_valid && !out_ready, since in_ready is low.
- Simultaneous consume + accept: new window loads, out_valid stays 1, no bubble.
- Lag read:
  - lag_data <= (lag < count) ? mem[(wptr-1-lag) mod M] : 0.
  - Address arithmetic is $clog2(M) bits, modulo M.
  - Lag read uses pre-update wptr/count; a same-cycle write is not visible until the next cycle.
- clear:
  - Forces PRIME, wptr=0, count=0, out_valid=0, x0..x2=0, lag_data=0.
  - Any in_valid in the same cycle is dropped.
- reset: same effect as clear; has priority over all other inputs.

## Timing
- Reset and clear values:
  - in_ready=0 during the reset/clear cycle, 1 after it.
  - out_valid=0, x0=x1=x2=0, lag_data=0, count=0.
- Window latency: 1 cycle. The sample accepted at edge k appears on x0 after edge k, with out_valid high when in STREAM.
- Lag read latency: 1 cycle (registered, synchronous RAM read).
- Throughput: 1 sample/cycle while out_ready is held high.
- count saturates at M. Further accepts overwrite the oldest entry; lag M-1 is then the oldest retained sample.
- Reset mid-stream: takes effect at the next edge. The window is lost and 3 new samples are needed before out_valid.

## Structure
- Package neo_pkg:
  - win_state_t enum {PRIME, STREAM}.
  - localparam NEO_TAPS = 3.
  - Helper function for modulo-M pointer decrement.
- Sub-module neo_sample_ram: simple dual-port RAM, one write port, one synchronous read port, parametrised N/M, no reset on the array.
- Top level holds wptr, count, window registers, FSM, handshake logic and the lag-gating mux.

## Test plan
- Reset, then feed 1, 2, 3 with out_ready=1 -> out_valid low after 1 and 2. After 3: x0=3, x1=2, x2=1, out_valid=1, count=3.
- Backpressure: out_ready=0 after the window (5,4,3), in_valid held with 6 -> in_ready=0, window unchanged. Raise out_ready -> 6 accepted, next window (6,5,4).
- Wrap, M=16: feed 0..19 -> count=16. lag=0 gives 19 after 1 cycle, lag=15 gives 4, wptr=4.
- Lag beyond fill: after 2 samples, lag=5 -> lag_data=0. lag=1 returns the first sample.
- clear with in_valid=1, in_data=-7 in the same cycle -> sample dropped, count=0, out_valid=0, x0..x2=0. The next 3 samples restart priming.
- Signed extremes, N=8: feed -128, 127, -1 -> x2=-128, x1=127, x0=-1 bit-exact, lag_data matches.

Source files
------------

// File: rtl/neo_pkg.sv
// rtl/neo_pkg.sv - shared types, constants and pointer helper for the NEO sample window
package neo_pkg;

    // PRIME until three samples have been seen since reset/clear, STREAM afterwards
    typedef enum logic {
        PRIME  = 1'b0,
        STREAM = 1'b1
    } win_state_t;

    // Number of taps the NEO datapath consumes: x[n], x[n-1], x[n-2]
    localparam int NEO_TAPS = 3;

    // Pointer decrement modulo a power-of-two depth; callers truncate to their pointer width
    function automatic int unsigned ptr_dec(input int unsigned ptr,
                                            input int unsigned dec,
                                            input int unsigned depth);
        return (ptr - dec) & (depth - 1);
    endfunction

endpackage

// File: rtl/neo_sample_ram.sv
// rtl/neo_sample_ram.sv - simple dual-port sample RAM, one write port, one registered read port
module neo_sample_ram #(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [$clog2(M)-1:0] waddr_i,
    input  logic [N-1:0]         wdata_i,
    input  logic [$clog2(M)-1:0] raddr_i,
    output logic [N-1:0]         rdata_o
);

    logic [N-1:0] mem_q [M];
    logic [N-1:0] rdata_q;

    // Write port; the array carries no reset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a same-cycle write to the read address returns the old word
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neo_sample_window.sv
// rtl/neo_sample_window.sv - circular sample buffer with three-tap window and lag read port
module neo_sample_window
    import neo_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    input  logic [N-1:0]         in_data_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [N-1:0]         x0_o,
    output logic [N-1:0]         x1_o,
    output logic [N-1:0]         x2_o,
    input  logic [$clog2(M)-1:0] lag_i,
    output logic [N-1:0]         lag_data_o,
    output logic [$clog2(M):0]   count_o
);

    localparam int AW = $clog2(M);

    win_state_t   state_q;
    logic         out_valid_q;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic [N-1:0]  x0_q, x1_q, x2_q;
    logic [N-1:0]  x0_d, x1_d, x2_d;
    logic          lag_hit_q, lag_hit_d;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          accept;

    // A held window blocks new samples; reset and clear also refuse input for their cycle
    assign in_ready_o = !reset_i && !clear_i && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Newest stored sample sits at wptr-1, so lag L lives at wptr-1-L
    assign rd_addr   = AW'(ptr_dec(32'(wptr_q), 32'(lag_i) + 32'd1, unsigned'(M)));
    assign lag_hit_d = ({1'b0, lag_i} < count_q);

    // Next-state for pointer, fill level and window shift register
    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        if (accept) begin
            wptr_d = wptr_q + AW'(1);
            if (count_q != (AW+1)'(M)) begin
                count_d = count_q + (AW+1)'(1);
            end
            x0_d = in_data_i;
            x1_d = x0_q;
            x2_d = x1_q;
        end
    end

    neo_sample_ram #(
        .N (N),
        .M (M)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (accept),
        .waddr_i (wptr_q),
        .wdata_i (in_data_i),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Priming FSM, handshake state and datapath registers; reset and clear flush everything but the RAM
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            state_q     <= PRIME;
            out_valid_q <= 1'b0;
            wptr_q      <= '0;
            count_q     <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            lag_hit_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            lag_hit_q <= lag_hit_d;
            case (state_q)
                PRIME: begin
                    if (accept && count_q == (AW+1)'(NEO_TAPS - 1)) begin
                        state_q     <= STREAM;
                        out_valid_q <= 1'b1;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                STREAM: begin
                    out_valid_q <= accept || (out_valid_q && !out_ready_i);
                end
                default: begin
                    state_q     <= PRIME;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign x0_o        = x0_q;
    assign x1_o        = x1_q;
    assign x2_o        = x2_q;
    assign count_o     = count_q;
    // Read data is gated by the hit flag registered alongside it, so unfilled lags read zero
    assign lag_data_o  = lag_hit_q ? rd_data : '0;

endmodule

// File: tb/tb_neo_sample_window.sv
// tb/tb_neo_sample_window.sv - self-checking bench for neo_sample_window
module tb_neo_sample_window;

    localparam int N  = 8;
    localparam int M  = 16;
    localparam int AW = $clog2(M);

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, out_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] lag;
    logic          in_ready, out_valid;
    logic [N-1:0]  x0, x1, x2, lag_data;
    logic [AW:0]   count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: samples stored since last reset/clear, newest at the back
    logic [N-1:0] hist[$];
    logic         m_ov;
    logic [N-1:0] m_lag;
    logic         exp_ready;
    logic         acc_pred;

    always #5 clk = ~clk;

    neo_sample_window #(.N(N), .M(M)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .x0_o       (x0),
        .x1_o       (x1),
        .x2_o       (x2),
        .lag_i      (lag),
        .lag_data_o (lag_data),
        .count_o    (count)
    );

    function automatic logic [N-1:0] m_x(input int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    task automatic apply(input logic v, input logic [N-1:0] d, input logic rdy,
                         input logic [AW-1:0] l, input logic clr, input logic rst);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        lag       = l;
        clear     = clr;
        reset     = rst;
        exp_ready = !rst && !clr && (!m_ov || rdy);
        acc_pred  = v && exp_ready;
        #1;
    endtask

    task automatic tick();
        if (reset || clear) begin
            hist.delete();
            m_ov  = 1'b0;
            m_lag = '0;
        end else begin
            m_lag = m_x(int'(lag));
            if (acc_pred) begin
                hist.push_back(in_data);
                if (hist.size() > M) void'(hist.pop_front());
                m_ov = (hist.size() >= 3);
            end else begin
                m_ov = m_ov && !out_ready;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [N-1:0] d);
        apply(1'b1, d, 1'b1, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        apply(1'b1, 8'd9, 1'b1, '0, 1'b0, 1'b1);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, x0, x1, x2, count, lag_data} !== {1'b0, 8'd0, 8'd0, 8'd0, 5'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got ov=%b x=%h/%h/%h cnt=%0d lag=%h want all zero",
                     out_valid, x0, x1, x2, count, lag_data);
        end
        apply(1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_prime();
        feed(8'd1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prime_after1: out_valid got %b want 0", out_valid);
        end
        feed(8'd2);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prime_after2: out_valid got %b want 0", out_valid);
        end
        feed(8'd3);
        tests_run++;
        if ({out_valid, x0, x1, x2, count} !== {1'b1, 8'd3, 8'd2, 8'd1, 5'd3}) begin
            tests_failed++;
            $display("FAIL prime_window: got ov=%b x=%0d/%0d/%0d cnt=%0d want 1 3/2/1 3",
                     out_valid, x0, x1, x2, count);
        end
    endtask

    task automatic test_backpressure();
        feed(8'd4);
        feed(8'd5);
        apply(1'b1, 8'd6, 1'b0, '0, 1'b0, 1'b0);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, x0, x1, x2} !== {1'b1, 8'd5, 8'd4, 8'd3}) begin
            tests_failed++;
            $display("FAIL bp_held: got ov=%b x=%0d/%0d/%0d want 1 5/4/3", out_valid, x0, x1, x2);
        end
        apply(1'b1, 8'd6, 1'b1, '0, 1'b0, 1'b0);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, x0, x1, x2} !== {1'b1, 8'd6, 8'd5, 8'd4}) begin
            tests_failed++;
            $display("FAIL bp_release: got ov=%b x=%0d/%0d/%0d want 1 6/5/4", out_valid, x0, x1, x2);
        end
    endtask

    task automatic test_wrap();
        apply(1'b0, '0, 1'b1, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 20; i++) feed(N'(i));
        tests_run++;
        if (count !== 5'd16) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d want 16", count);
        end
        apply(1'b0, '0, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (lag_data !== 8'd19) begin
            tests_failed++;
            $display("FAIL wrap_lag0: got %0d want 19", lag_data);
        end
        apply(1'b0, '0, 1'b1, 4'd15, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (lag_data !== 8'd4) begin
            tests_failed++;
            $display("FAIL wrap_lag15: got %0d want 4", lag_data);
        end
    endtask

    task automatic test_lag_fill();
        apply(1'b0, '0, 1'b1, '0, 1'b0, 1'b1);
        tick();
        feed(8'd10);
        feed(8'd20);
        apply(1'b0, '0, 1'b1, 4'd5, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (lag_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL lag_beyond_fill: got %0d want 0", lag_data);
        end
        apply(1'b0, '0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (lag_data !== 8'd10) begin
            tests_failed++;
            $display("FAIL lag_first_sample: got %0d want 10", lag_data);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) feed(N'(i + 40));
        apply(1'b1, 8'hF9, 1'b1, 4'd0, 1'b1, 1'b0);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_in_ready: got %b want 0", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, x0, x1, x2, count, lag_data} !== {1'b0, 8'd0, 8'd0, 8'd0, 5'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL clear_state: got ov=%b x=%h/%h/%h cnt=%0d lag=%h want all zero",
                     out_valid, x0, x1, x2, count, lag_data);
        end
        feed(8'd7);
        feed(8'd8);
        tests_run++;
        if (out_valid !== 1'b0 || count !== 5'd2) begin
            tests_failed++;
            $display("FAIL clear_reprime: got ov=%b cnt=%0d want 0 2", out_valid, count);
        end
        feed(8'd9);
        tests_run++;
        if ({out_valid, x0, x1, x2} !== {1'b1, 8'd9, 8'd8, 8'd7}) begin
            tests_failed++;
            $display("FAIL clear_restream: got ov=%b x=%0d/%0d/%0d want 1 9/8/7", out_valid, x0, x1, x2);
        end
    endtask

    task automatic test_signed();
        apply(1'b0, '0, 1'b1, '0, 1'b0, 1'b1);
        tick();
        feed(8'h80);
        feed(8'h7F);
        feed(8'hFF);
        tests_run++;
        if ({x0, x1, x2} !== {8'hFF, 8'h7F, 8'h80}) begin
            tests_failed++;
            $display("FAIL signed_window: got %h/%h/%h want ff/7f/80", x0, x1, x2);
        end
        apply(1'b0, '0, 1'b1, 4'd2, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (lag_data !== 8'h80) begin
            tests_failed++;
            $display("FAIL signed_lag2: got %h want 80", lag_data);
        end
        apply(1'b0, '0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (lag_data !== 8'h7F) begin
            tests_failed++;
            $display("FAIL signed_lag1: got %h want 7f", lag_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 3) != 0, N'($urandom), $urandom_range(0, 2) != 0,
                  AW'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
            tests_run++;
            if (in_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rand_in_ready cyc %0d: got %b want %b", i, in_ready, exp_ready);
            end
            tick();
            tests_run++;
            if ({out_valid, x0, x1, x2, count, lag_data} !==
                {m_ov, m_x(0), m_x(1), m_x(2), (AW+1)'(hist.size()), m_lag}) begin
                tests_failed++;
                $display("FAIL rand_outputs cyc %0d: got ov=%b x=%h/%h/%h cnt=%0d lag=%h want ov=%b x=%h/%h/%h cnt=%0d lag=%h",
                         i, out_valid, x0, x1, x2, count, lag_data,
                         m_ov, m_x(0), m_x(1), m_x(2), hist.size(), m_lag);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        lag       = '0;
        m_ov      = 1'b0;
        m_lag     = '0;
        exp_ready = 1'b0;
        acc_pred  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_prime();
        test_backpressure();
        test_wrap();
        test_lag_fill();
        test_clear();
        test_signed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
